// File: rtl/cpu_port_pio_if.sv
// cpu_port_pio_if: CPU-side bus control (ownership, direction, address) into the port.
interface cpu_port_pio_if;
    logic        aec;
    logic        r_w_in;
    logic [15:0] address_in;
    modport master (output aec, r_w_in, address_in);
    modport slave  (input  aec, r_w_in, address_in);
endinterface

// File: rtl/cpu_port_pio.sv
// cpu_port_pio: 6510-style two-register I/O port and tristating bus adapter; CPU_PORT_FADE_EN adds charge retention.
module cpu_port_pio #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [15:0]           BASE_ADDR   = 16'h0000,
    parameter logic [DATA_WIDTH-1:0] IMPL_MASK   = 8'hDF,
    parameter bit                    PASS_WRITES = 1'b1,
    parameter logic [DATA_WIDTH-1:0] FADE_MASK   = 8'hC0,
    parameter logic [23:0]           FADE_CYCLES = 24'd1000000
) (
    input  logic                  clock,
    input  logic                  _reset,
    cpu_port_pio_if.slave         cpu,
    output wire [15:0]            address_out,
    output wire                   r_w_out,
    inout  wire [DATA_WIDTH-1:0]  data_cpu,
    inout  wire [DATA_WIDTH-1:0]  data_ext,
    inout  wire [DATA_WIDTH-1:0]  pio
);
    logic [DATA_WIDTH-1:0] r_ddr, r_out, r_s1, r_s2;
    logic [DATA_WIDTH-1:0] w_ddr_nxt, w_in, w_dat, w_rd;
    logic                  w_hit_ddr, w_hit_dat, w_hit, w_wr, w_block;
    assign w_hit_ddr = cpu.aec & (cpu.address_in == BASE_ADDR);
    assign w_hit_dat = cpu.aec & (cpu.address_in == 16'(BASE_ADDR + 16'd1));
    assign w_hit     = w_hit_ddr | w_hit_dat;
    assign w_wr      = ~cpu.r_w_in;
    assign w_block   = w_hit & ~PASS_WRITES;
    assign w_ddr_nxt = (w_hit_ddr & w_wr) ? (data_cpu & IMPL_MASK) : r_ddr;
    always_ff @(negedge clock or negedge _reset) begin
        if (!_reset) begin
            r_ddr <= '0;
            r_out <= '0;
            r_s1  <= '0;
            r_s2  <= '0;
        end else begin
            r_ddr <= w_ddr_nxt;
            if (w_hit_dat & w_wr) r_out <= data_cpu & IMPL_MASK;
            r_s1  <= pio;
            r_s2  <= r_s1;
        end
    end
`ifdef CPU_PORT_FADE_EN
    localparam logic [DATA_WIDTH-1:0] FM = FADE_MASK & IMPL_MASK;
    logic [DATA_WIDTH-1:0] r_ret;
    logic [23:0]           r_cnt [DATA_WIDTH];
    // Counter hitting zero and the retained charge decaying happen on the same edge.
    always_ff @(negedge clock or negedge _reset) begin
        if (!_reset) begin
            r_ret <= '0;
            for (int i = 0; i < DATA_WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (FM[i]) begin
                    if (r_ddr[i] & ~w_ddr_nxt[i]) begin
                        r_ret[i] <= r_out[i];
                        r_cnt[i] <= FADE_CYCLES;
                    end else if (w_ddr_nxt[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] > 24'd1) begin
                        r_cnt[i] <= r_cnt[i] - 24'd1;
                    end else begin
                        r_cnt[i] <= '0;
                        r_ret[i] <= 1'b0;
                    end
                end
            end
        end
    end
    assign w_in = (FM & r_ret) | (~FM & r_s2);
`else
    assign w_in = r_s2;
`endif
    assign w_dat = IMPL_MASK & ((r_ddr & r_out) | (~r_ddr & w_in));
    assign w_rd  = w_hit_ddr ? r_ddr : w_dat;
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pio
        assign pio[i] = (IMPL_MASK[i] & r_ddr[i]) ? r_out[i] : 1'bz;
    end
    assign data_cpu    = (cpu.aec & cpu.r_w_in) ? (w_hit ? w_rd : data_ext) : 'z;
    assign data_ext    = (cpu.aec & w_wr & ~w_block) ? data_cpu : 'z;
    assign address_out = cpu.aec ? cpu.address_in : 'z;
    assign r_w_out     = cpu.aec ? (cpu.r_w_in | w_block) : 1'bz;
endmodule

// File: tb/tb_cpu_port_pio.sv
// tb_cpu_port_pio: directed checks of decode, port registers, tristating, sync delay and retention.
module tb_cpu_port_pio;
    logic clock = 1'b0;
    logic _reset = 1'b0;
    always #5 clock = ~clock;
    cpu_port_pio_if bus ();
    wire [15:0] ao0, ao1;
    wire        rw0, rw1;
    wire [7:0]  dc0, dc1, de0, de1, p0, p1;
    logic       tb_doe = 1'b0, tb_eoe = 1'b0;
    logic [7:0] tb_dval = '0, tb_eval = '0, tb_poe = '0, tb_pval = '0;
    int total = 0;
    int bad = 0;
    // Pull-ups make an undriven net read as all ones.
    for (genvar g = 0; g < 16; g++) begin : g_pa
        pullup (ao0[g]);
        pullup (ao1[g]);
    end
    pullup (rw0);
    pullup (rw1);
    for (genvar g = 0; g < 8; g++) begin : g_pd
        pullup (dc0[g]);
        pullup (dc1[g]);
        pullup (de0[g]);
        pullup (de1[g]);
        pullup (p0[g]);
        pullup (p1[g]);
        assign dc0[g] = tb_doe ? tb_dval[g] : 1'bz;
        assign dc1[g] = tb_doe ? tb_dval[g] : 1'bz;
        assign de0[g] = tb_eoe ? tb_eval[g] : 1'bz;
        assign de1[g] = tb_eoe ? tb_eval[g] : 1'bz;
        assign p0[g]  = tb_poe[g] ? tb_pval[g] : 1'bz;
        assign p1[g]  = tb_poe[g] ? tb_pval[g] : 1'bz;
    end
    cpu_port_pio u0 (
        .clock(clock), ._reset(_reset), .cpu(bus),
        .address_out(ao0), .r_w_out(rw0), .data_cpu(dc0), .data_ext(de0), .pio(p0)
    );
    cpu_port_pio #(.PASS_WRITES(1'b0), .FADE_CYCLES(24'd16)) u1 (
        .clock(clock), ._reset(_reset), .cpu(bus),
        .address_out(ao1), .r_w_out(rw1), .data_cpu(dc1), .data_ext(de1), .pio(p1)
    );
    task automatic drive(input logic a, input logic rw, input logic [15:0] ad, input logic [7:0] d);
        @(posedge clock);
        bus.aec = a;
        bus.r_w_in = rw;
        bus.address_in = ad;
        tb_doe = ~rw;
        tb_dval = d;
        #1;
    endtask
    task automatic test_reset;
        logic [7:0] exp_in;
`ifdef CPU_PORT_FADE_EN
        exp_in = 8'h1F;
`else
        exp_in = 8'hDF;
`endif
        drive(1'b1, 1'b1, 16'h0000, 8'h00);
        total++; if (dc0 !== 8'h00) begin bad++; $display("FAIL reset_ddr_read got=%h exp=00", dc0); end
        total++; if (p0 !== 8'hFF) begin bad++; $display("FAIL reset_pio_z got=%h exp=ff", p0); end
        _reset = 1'b1;
        repeat (3) drive(1'b1, 1'b1, 16'h0001, 8'h00);
        total++; if (dc0 !== exp_in) begin bad++; $display("FAIL reset_pin_read got=%h exp=%h", dc0, exp_in); end
        total++; if (ao0 !== 16'h0001 || rw0 !== 1'b1) begin bad++; $display("FAIL reset_bus got=%h/%b exp=0001/1", ao0, rw0); end
        total++; if (de0 !== 8'hFF) begin bad++; $display("FAIL reset_ext_z got=%h exp=ff", de0); end
    endtask
    task automatic test_port;
        drive(1'b1, 1'b0, 16'h0000, 8'hFF);
        total++; if (de0 !== 8'hFF || rw0 !== 1'b0 || ao0 !== 16'h0000) begin bad++; $display("FAIL ddr_write_bus got=%h/%b/%h exp=ff/0/0000", de0, rw0, ao0); end
        total++; if (rw1 !== 1'b1) begin bad++; $display("FAIL ddr_write_nopass_rw got=%b exp=1", rw1); end
        drive(1'b1, 1'b0, 16'h0001, 8'hA5);
        drive(1'b1, 1'b1, 16'h0001, 8'h00);
        total++; if (dc0 !== 8'h85) begin bad++; $display("FAIL dat_read got=%h exp=85", dc0); end
        total++; if (dc1 !== 8'h85) begin bad++; $display("FAIL dat_read_u1 got=%h exp=85", dc1); end
        total++; if (p0 !== 8'hA5) begin bad++; $display("FAIL pio_drive got=%h exp=a5", p0); end
        drive(1'b1, 1'b1, 16'h0000, 8'h00);
        total++; if (dc0 !== 8'hDF) begin bad++; $display("FAIL ddr_read got=%h exp=df", dc0); end
    endtask
    task automatic test_pass_writes;
        drive(1'b1, 1'b0, 16'h0001, 8'h3C);
        total++; if (rw1 !== 1'b1 || de1 !== 8'hFF) begin bad++; $display("FAIL nopass_hit got=%b/%h exp=1/ff", rw1, de1); end
        total++; if (rw0 !== 1'b0 || de0 !== 8'h3C) begin bad++; $display("FAIL pass_hit got=%b/%h exp=0/3c", rw0, de0); end
        drive(1'b1, 1'b0, 16'h1234, 8'h77);
        total++; if (rw1 !== 1'b0 || de1 !== 8'h77 || ao1 !== 16'h1234) begin bad++; $display("FAIL nopass_miss got=%b/%h/%h exp=0/77/1234", rw1, de1, ao1); end
        tb_eoe = 1'b1;
        tb_eval = 8'h5A;
        drive(1'b1, 1'b1, 16'h1234, 8'h00);
        total++; if (dc0 !== 8'h5A) begin bad++; $display("FAIL ext_read got=%h exp=5a", dc0); end
        drive(1'b1, 1'b1, 16'h0001, 8'h00);
        total++; if (dc0 !== 8'h1C) begin bad++; $display("FAIL hit_ignores_ext got=%h exp=1c", dc0); end
        tb_eoe = 1'b0;
    endtask
    task automatic test_aec;
        drive(1'b0, 1'b1, 16'hD000, 8'h00);
        total++; if (ao0 !== 16'hFFFF || rw0 !== 1'b1) begin bad++; $display("FAIL aec_off_bus got=%h/%b exp=ffff/1", ao0, rw0); end
        total++; if (dc0 !== 8'hFF || de0 !== 8'hFF) begin bad++; $display("FAIL aec_off_data got=%h/%h exp=ff/ff", dc0, de0); end
        drive(1'b0, 1'b0, 16'h0001, 8'h00);
        total++; if (rw0 !== 1'b1 || de0 !== 8'hFF || ao0 !== 16'hFFFF) begin bad++; $display("FAIL aec_off_write got=%b/%h/%h exp=1/ff/ffff", rw0, de0, ao0); end
        drive(1'b1, 1'b1, 16'h0001, 8'h00);
        total++; if (dc0 !== 8'h1C) begin bad++; $display("FAIL aec_off_no_commit got=%h exp=1c", dc0); end
    endtask
    task automatic test_sync;
        tb_poe = 8'h01;
        tb_pval = 8'h00;
        drive(1'b1, 1'b0, 16'h0000, 8'h00);
        repeat (3) drive(1'b1, 1'b1, 16'h0001, 8'h00);
        tb_pval = 8'h01;
        #1;
        total++; if (dc0[5:0] !== 6'h1E) begin bad++; $display("FAIL sync_s0 got=%h exp=1e", dc0[5:0]); end
        drive(1'b1, 1'b1, 16'h0001, 8'h00);
        total++; if (dc0[5:0] !== 6'h1E) begin bad++; $display("FAIL sync_s1 got=%h exp=1e", dc0[5:0]); end
        drive(1'b1, 1'b1, 16'h0001, 8'h00);
        total++; if (dc0[5:0] !== 6'h1F) begin bad++; $display("FAIL sync_s2 got=%h exp=1f", dc0[5:0]); end
        tb_poe = 8'h00;
    endtask
`ifdef CPU_PORT_FADE_EN
    task automatic test_fade;
        logic [1:0] exp;
        drive(1'b1, 1'b0, 16'h0001, 8'hC0);
        drive(1'b1, 1'b0, 16'h0000, 8'hC0);
        drive(1'b1, 1'b0, 16'h0000, 8'h00);
        @(negedge clock);
        #1;
        tb_poe = 8'hC0;
        tb_pval = 8'h00;
        for (int k = 0; k < 20; k++) begin
            exp = (k < 16) ? 2'b11 : 2'b00;
            drive(1'b1, 1'b1, 16'h0001, 8'h00);
            total++; if (dc1[7:6] !== exp) begin bad++; $display("FAIL fade_k%0d got=%b exp=%b", k, dc1[7:6], exp); end
        end
        tb_poe = 8'h00;
    endtask
`endif
    initial begin
        bus.aec = 1'b0;
        bus.r_w_in = 1'b1;
        bus.address_in = 16'h0000;
        test_reset;
        test_port;
        test_pass_writes;
        test_aec;
        test_sync;
`ifdef CPU_PORT_FADE_EN
        test_fade;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
